// File: rtl/clk_edge_monitor_pkg.sv
// Shared definitions for the divided-clock edge monitor.
// State encoding plus default ratio/timeout values shared with the divider.
package clk_edge_monitor_pkg;

  localparam int unsigned DEF_EXP_HALF   = 2;
  localparam int unsigned DEF_LOCK_COUNT = 4;
  localparam int unsigned DEF_TIMEOUT    = 64;
  localparam int unsigned DEF_CNT_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } mon_state_e;

  // An edge yields a measurement only once a reference edge has been seen,
  // which is exactly the ACQUIRE and LOCKED states.
  function automatic logic is_measuring(input mon_state_e s);
    return (s == ST_ACQUIRE) || (s == ST_LOCKED);
  endfunction

endpackage

// File: rtl/clk_edge_monitor_sync_edge_detect.sv
// 3-flop synchroniser for an asynchronous level, plus registered rise/fall ticks.
// Ports: clk_i, rst_i (async high), async_i in; edge_o (comb), rise_o, fall_o out.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic rise_q;
  logic fall_q;

  // s1/s2 form the metastability chain; s3 is the history bit.
  assign edge_o = s2_q ^ s3_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

endmodule

// File: rtl/clk_edge_monitor.sv
// Receives a divided clock as data, emits rise/fall ticks, measures half-periods
// and reports locked/lost. Ports: clk, rst, slow_in; rise_tick, fall_tick,
// half_period, period_valid, locked, lost.
module clk_edge_monitor
  import clk_edge_monitor_pkg::*;
#(
  parameter int unsigned EXP_HALF   = DEF_EXP_HALF,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

  logic             edge_det;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] meas;
  logic [CNT_W-1:0] hp_q;
  logic [CNT_W-1:0] hp_d;
  logic             pv_q;
  logic             locked_q;
  logic             lost_q;
  logic [MW-1:0]    mcnt_q;
  logic [MW-1:0]    mcnt_d;
  logic             timeout;
  logic             match;
  logic             measuring;
  mon_state_e       state_q;
  mon_state_e       state_d;

  sync_edge_detect u_sync_edge_detect (
    .clk_i   (clk),
    .rst_i   (rst),
    .async_i (slow_in),
    .edge_o  (edge_det),
    .rise_o  (rise_tick),
    .fall_o  (fall_tick)
  );

  // cnt counts cycles since the previous edge minus one, so the interval
  // between two edge conditions is cnt + 1.
  assign meas      = cnt_q + CNT_W'(1);
  assign match     = (meas == CNT_W'(EXP_HALF));
  assign timeout   = (cnt_q == CNT_W'(TIMEOUT));
  assign measuring = edge_det && is_measuring(state_q);

  assign half_period  = hp_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign lost         = lost_q;

  always_comb begin
    cnt_d = cnt_q;
    if (edge_det) begin
      cnt_d = '0;
    end else if (!timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    hp_d = hp_q;
    if (measuring) begin
      hp_d = meas;
    end
  end

  // An edge always takes priority over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (edge_det) begin
          state_d = ST_ACQUIRE;
          mcnt_d  = '0;
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_ACQUIRE: begin
        if (edge_det) begin
          if (!match) begin
            mcnt_d = '0;
          end else if (mcnt_q == MW'(LOCK_COUNT - 1)) begin
            state_d = ST_LOCKED;
            mcnt_d  = '0;
          end else begin
            mcnt_d = mcnt_q + MW'(1);
          end
        end else if (timeout) begin
          state_d = ST_LOST;
          mcnt_d  = '0;
        end
      end
      ST_LOCKED: begin
        if (edge_det) begin
          if (!match) begin
            state_d = ST_ACQUIRE;
            mcnt_d  = '0;
          end
        end else if (timeout) begin
          state_d = ST_LOST;
          mcnt_d  = '0;
        end
      end
      ST_LOST: begin
        if (edge_det) begin
          state_d = ST_ACQUIRE;
          mcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // locked/lost follow the state one cycle later, so they move the cycle
  // after the tick/period_valid that caused the transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      hp_q     <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hp_q     <= hp_d;
      pv_q     <= measuring;
      locked_q <= (state_q == ST_LOCKED);
      lost_q   <= (state_q == ST_LOST);
    end
  end

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Scoreboard bench for clk_edge_monitor.
// Directed slow_in toggles push expected ticks, measurements and level changes.
module tb_clk_edge_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slow_in = 1'b0;
  logic        rise_tick;
  logic        fall_tick;
  logic [31:0] half_period;
  logic        period_valid;
  logic        locked;
  logic        lost;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_c = 0;

  typedef struct {
    int cyc;
    bit val;
  } tick_t;

  typedef struct {
    int cyc;
    int half;
  } pv_t;

  typedef struct {
    int cyc;
    bit is_lost;
    bit val;
  } lvl_t;

  tick_t tq[$];
  pv_t   pq[$];
  lvl_t  lq[$];

  clk_edge_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .slow_in      (slow_in),
    .rise_tick    (rise_tick),
    .fall_tick    (fall_tick),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_lvl(input int c, input bit is_lost, input bit v);
    lvl_t e;
    e.cyc = c;
    e.is_lost = is_lost;
    e.val = v;
    lq.push_back(e);
  endtask

  // Toggle slow_in now; tick/pv seen 3 cycles later, level change 4 later.
  task automatic tog(input bit meas, input int half, input int lk, input int ls);
    tick_t t;
    pv_t p;
    slow_in = ~slow_in;
    last_c = cyc;
    t.cyc = cyc + 3;
    t.val = slow_in;
    tq.push_back(t);
    if (meas) begin
      p.cyc = cyc + 3;
      p.half = half;
      pq.push_back(p);
    end
    if (lk >= 0) push_lvl(cyc + 4, 1'b0, lk[0]);
    if (ls >= 0) push_lvl(cyc + 4, 1'b1, ls[0]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rise"}, rise_tick, 0);
    chk({tag, "_fall"}, fall_tick, 0);
    chk({tag, "_pv"}, period_valid, 0);
    chk({tag, "_half"}, half_period, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_lost"}, lost, 0);
  endtask

  // Monitor: every tick, measurement and level change must match the queue head.
  initial begin
    bit pl;
    bit ps;
    tick_t t;
    pv_t p;
    lvl_t e;
    pl = 1'b0;
    ps = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rise_tick && fall_tick) chk("tick_both", 1, 0);
      if (rise_tick || fall_tick) begin
        if (tq.size() == 0) begin
          chk("tick_unexpected", cyc, -1);
        end else begin
          t = tq.pop_front();
          chk("tick_cycle", cyc, t.cyc);
          chk("tick_rise", rise_tick, t.val);
        end
      end
      if (period_valid) begin
        if (pq.size() == 0) begin
          chk("pv_unexpected", cyc, -1);
        end else begin
          p = pq.pop_front();
          chk("pv_cycle", cyc, p.cyc);
          chk("half_period", half_period, p.half);
        end
      end
      if (locked && lost) chk("locked_and_lost", 1, 0);
      if (locked !== pl) begin
        if (lq.size() == 0) begin
          chk("locked_unexpected", cyc, -1);
        end else begin
          e = lq.pop_front();
          chk("locked_kind", e.is_lost, 0);
          chk("locked_cycle", cyc, e.cyc);
          chk("locked_val", locked, e.val);
        end
        pl = locked;
      end
      if (lost !== ps) begin
        if (lq.size() == 0) begin
          chk("lost_unexpected", cyc, -1);
        end else begin
          e = lq.pop_front();
          chk("lost_kind", e.is_lost, 1);
          chk("lost_cycle", cyc, e.cyc);
          chk("lost_val", lost, e.val);
        end
        ps = lost;
      end
    end
  end

  initial begin
    // Reset, slow_in low: everything 0, then timeout from IDLE.
    wait_cyc(3);
    chk_all_zero("reset");
    rst = 1'b0;
    push_lvl(cyc + 66, 1'b1, 1'b1);
    wait_cyc(70);
    chk("idle_timeout_lost", lost, 1);
    chk("idle_timeout_locked", locked, 0);

    // Leave LOST, acquire with 2-cycle halves, then stay locked.
    tog(0, 0, -1, 0);
    wait_cyc(2);
    for (int i = 0; i < 3; i++) begin
      tog(1, 2, -1, -1);
      wait_cyc(2);
    end
    tog(1, 2, 1, -1);
    wait_cyc(2);
    for (int i = 0; i < 2; i++) begin
      tog(1, 2, -1, -1);
      wait_cyc(2);
    end

    // One stretched half drops lock; four good halves regain it.
    wait_cyc(1);
    tog(1, 3, 0, -1);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(2);
      tog(1, 2, (i == 3) ? 1 : -1, -1);
    end

    // Freeze while locked: lost and unlock together, half_period held.
    push_lvl(last_c + 69, 1'b0, 1'b0);
    push_lvl(last_c + 69, 1'b1, 1'b1);
    wait_cyc(75);
    chk("lost_hold_half", half_period, 2);
    chk("freeze_lost", lost, 1);
    tog(0, 0, -1, 0);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(2);
      tog(1, 2, (i == 3) ? 1 : -1, -1);
    end

    // Edge on the exact timeout cycle: measured as 65, no lost.
    wait_cyc(65);
    tog(1, 65, 0, -1);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(2);
      tog(1, 2, (i == 3) ? 1 : -1, -1);
    end
    wait_cyc(6);
    chk("pre_reset_locked", locked, 1);
    chk("pre_reset_lost", lost, 0);

    // Async reset mid-lock, then re-acquire as after power-up.
    rst = 1'b1;
    push_lvl(cyc + 1, 1'b0, 1'b0);
    #1;
    chk_all_zero("midreset");
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(3);
    tog(0, 0, -1, -1);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(2);
      tog(1, 2, (i == 3) ? 1 : -1, -1);
    end
    wait_cyc(10);
    chk("final_locked", locked, 1);
    chk("tick_q_empty", tq.size(), 0);
    chk("pv_q_empty", pq.size(), 0);
    chk("lvl_q_empty", lq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_edge_monitor.md
Name: clk_edge_monitor

Overview:
- Receiving end of the clock divider output.
- Takes a divided clock (slow_in) as a plain data input, synchronises it into the clk domain and emits single-cycle rise/fall ticks.
- Measures each half-period in clk cycles and reports lock when the measured half-period matches the expected divide ratio.
- Downstream logic uses the ticks as clock enables instead of clocking flops from a divided clock.

Parameters:
- EXP_HALF, 2: expected half-period in clk cycles (the divider ratio); legal range 2..TIMEOUT-1.
- LOCK_COUNT, 4: consecutive matching measurements required to assert locked; legal range ≥1.
- TIMEOUT, 64: clk cycles without an edge before lost; must be < 2^CNT_W - 1.
- CNT_W, 32: width of the internal counter and of half_period.

Ports:
- clk, input, 1: single system clock; all flops on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- slow_in, input, 1: divided clock, asynchronous to clk.
- rise_tick, output, 1: one-cycle pulse per synchronised rising edge.
- fall_tick, output, 1: one-cycle pulse per synchronised falling edge.
- half_period, output, CNT_W: last measured edge-to-edge interval in clk cycles.
- period_valid, output, 1: one-cycle pulse when half_period updates.
- locked, output, 1: level; input matches EXP_HALF.
- lost, output, 1: level; no edge for TIMEOUT cycles.

Behaviour:
- Reset: all outputs 0, synchroniser flops 0, counter 0, match count 0, state IDLE. Reset asserted mid-operation clears everything immediately (asynchronous); lock must be re-acquired from scratch.
- Synchroniser: s1 <= slow_in, s2 <= s1, s3 <= s2.
- Edge condition: s2 != s3.
  - rise_tick <= s2 & ~s3; fall_tick <= ~s2 & s3 (both registered).
  - slow_in change sampled at clk edge k gives a tick high for exactly the cycle after edge k+2 (3-cycle latency).
- Interval counter:
  - Cleared to 0 in any cycle with an edge condition.
  - Otherwise increments, saturating at TIMEOUT (never wraps).
- Measurement:
  - On an edge condition with first_seen=1: half_period <= cnt+1 and period_valid pulses in the same cycle as the tick.
  - The first edge after reset or after LOST only sets first_seen; no measurement and no period_valid.
- match = (cnt+1 == EXP_HALF) at a measuring edge.
- State machine:
  - IDLE: first edge -> ACQUIRE (first_seen=1). cnt reaching TIMEOUT -> LOST.
  - ACQUIRE: measurement with match increments the match count; when the count reaches LOCK_COUNT -> LOCKED. Mismatch clears the match count to 0. Timeout -> LOST.
  - LOCKED: locked=1. Any mismatching measurement -> ACQUIRE with match count 0 and locked deasserted next cycle. Timeout -> LOST.
  - LOST: lost=1, locked=0, first_seen=0. Next edge -> ACQUIRE; lost clears the cycle after that edge's tick.
- Simultaneous edge and timeout in the same cycle: the edge wins; no LOST transition.
- Locked and lost are never both 1.
- half_period holds its last value through LOST; it is not cleared except by reset.
- Slow_in pulses shorter than one clk cycle may be missed; this is not an error condition.

Decomposition:
- Shared package: state encoding constants (IDLE, ACQUIRE, LOCKED, LOST; 2 bits) and default values for EXP_HALF/TIMEOUT, reused by the divider instantiation so both ends agree on the ratio.
- One sub-module: sync_edge_detect (3-flop synchroniser plus registered rise/fall tick generation).
- The counter and FSM stay in the top level.

Test Plan:
- Reset release, slow_in held 0 -> all outputs 0; after 64 cycles lost=1, locked=0.
- slow_in toggling every 2 clk cycles -> alternating rise/fall ticks every 2 cycles; first edge gives no period_valid; half_period=2 on each subsequent edge; locked=1 in the cycle after the 4th matching measurement.
- While locked, stretch one half-period to 3 cycles -> period_valid with half_period=3, locked falls next cycle; 4 more 2-cycle halves -> locked=1 again.
- While locked, freeze slow_in -> lost=1 exactly when cnt hits 64; resume toggling -> lost clears after the first edge; locked re-acquired only after 1 unmeasured edge plus 4 matching measurements.
- Edge arriving on the exact cycle cnt reaches TIMEOUT -> no lost assertion; half_period=65.
- Assert rst for one cycle mid-lock -> all outputs 0 immediately; re-acquisition follows the same sequence as after power-up.
